// File: rtl/gpioemu_pkg.sv
// rtl/gpioemu_pkg.sv - shared addresses, status codes and state types for the gpioemu bus master
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam logic [1:0] STATUS_DONE = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_POLL,
    ST_GAP,
    ST_RD_W,
    ST_RD_L,
    ST_RESP
  } master_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_t;

endpackage

// File: rtl/gpioemu_bus_access.sv
// rtl/gpioemu_bus_access.sv - single setup/strobe/hold access on the saddress/srd/swr bus
module gpioemu_bus_access
  import gpioemu_pkg::*;
#(
  parameter int STROBE_LEN = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  bus_phase_t phase;
  logic [7:0] strobe_cnt;
  logic       we_q;

  // A new access may be loaded while idle or on the edge that closes HOLD,
  // so the master can chain accesses with no idle cycle in between.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      phase      <= PH_IDLE;
      strobe_cnt <= 8'd0;
      we_q       <= 1'b0;
      saddress   <= 16'h0000;
      sdata_out  <= 32'h0000_0000;
      swr        <= 1'b0;
      srd        <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE, PH_HOLD: begin
          if (start) begin
            saddress  <= addr;
            sdata_out <= wdata;
            we_q      <= we;
            phase     <= PH_SETUP;
          end else begin
            phase <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          swr        <= we_q;
          srd        <= ~we_q;
          strobe_cnt <= 8'd0;
          phase      <= PH_STROBE;
        end
        PH_STROBE: begin
          if (strobe_cnt == 8'(STROBE_LEN - 1)) begin
            swr   <= 1'b0;
            srd   <= 1'b0;
            phase <= PH_HOLD;
          end else begin
            strobe_cnt <= strobe_cnt + 8'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  // The master samples rdata on the edge that ends HOLD, i.e. while done is high.
  assign done  = (phase == PH_HOLD);
  assign rdata = sdata_in;

endmodule

// File: rtl/gpioemu_bus_master.sv
// rtl/gpioemu_bus_master.sv - job FSM driving the gpioemu multiply/popcount peripheral
module gpioemu_bus_master
  import gpioemu_pkg::*;
#(
  parameter int STROBE_LEN = 2,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_ones,
  output logic        res_ovf,
  output logic        res_timeout,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        busy,
  output logic [15:0] job_count
);

  master_state_t state;
  logic          kick;
  logic [23:0]   a1_q;
  logic [23:0]   a2_q;
  logic [15:0]   poll_cnt;
  logic [15:0]   gap_cnt;

  logic          acc_start;
  logic          acc_we;
  logic [15:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_done;
  logic [31:0]   acc_rdata;
  logic          last_poll;
  logic          status_done;

  assign last_poll   = ((poll_cnt + 16'd1) == 16'(POLL_LIMIT));
  assign status_done = (acc_rdata[1:0] == STATUS_DONE);

  // Launch decode: the first access is kicked one cycle after accept; later
  // accesses are launched on the done of the previous one, or at the last gap cycle.
  always_comb begin
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = ADDR_CTRL;
    acc_wdata = 32'h0000_0000;
    case (state)
      ST_WR_A1: begin
        if (kick) begin
          acc_start = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_A1;
          acc_wdata = {8'h00, a1_q};
        end else if (acc_done) begin
          acc_start = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_A2;
          acc_wdata = {8'h00, a2_q};
        end
      end
      ST_WR_A2: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_CTRL;
        end
      end
      ST_WR_GO: begin
        acc_start = acc_done;
      end
      ST_POLL: begin
        if (acc_done) begin
          if (status_done) begin
            acc_start = 1'b1;
            acc_addr  = ADDR_W;
          end else if (!last_poll && (POLL_GAP == 0)) begin
            acc_start = 1'b1;
          end
        end
      end
      ST_GAP: begin
        acc_start = (gap_cnt == 16'd1);
      end
      ST_RD_W: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = ADDR_L;
        end
      end
      default: acc_start = 1'b0;
    endcase
  end

  // Job FSM with registered handshake, result and status outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      kick        <= 1'b0;
      a1_q        <= 24'h0;
      a2_q        <= 24'h0;
      poll_cnt    <= 16'h0;
      gap_cnt     <= 16'h0;
      job_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_w       <= 32'h0;
      res_ones    <= 6'h0;
      res_ovf     <= 1'b0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      job_count   <= 16'h0;
    end else begin
      kick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            a1_q        <= job_a1;
            a2_q        <= job_a2;
            res_w       <= 32'h0;
            res_ones    <= 6'h0;
            res_ovf     <= 1'b0;
            res_timeout <= 1'b0;
            poll_cnt    <= 16'h0;
            kick        <= 1'b1;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_WR_A1;
          end
        end
        ST_WR_A1: if (acc_done) state <= ST_WR_A2;
        ST_WR_A2: if (acc_done) state <= ST_WR_GO;
        ST_WR_GO: if (acc_done) state <= ST_POLL;
        ST_POLL: begin
          if (acc_done) begin
            if (!acc_rdata[0]) res_ovf <= 1'b1;
            if (status_done) begin
              state <= ST_RD_W;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
              if (last_poll) begin
                res_timeout <= 1'b1;
                res_valid   <= 1'b1;
                state       <= ST_RESP;
              end else if (POLL_GAP != 0) begin
                gap_cnt <= 16'(POLL_GAP);
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'd1) state <= ST_POLL;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        ST_RD_W: begin
          if (acc_done) begin
            res_w <= acc_rdata;
            state <= ST_RD_L;
          end
        end
        ST_RD_L: begin
          if (acc_done) begin
            res_ones  <= acc_rdata[5:0];
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_count <= job_count + 16'd1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  gpioemu_bus_access #(
    .STROBE_LEN(STROBE_LEN)
  ) u_access (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (acc_start),
    .we        (acc_we),
    .addr      (acc_addr),
    .wdata     (acc_wdata),
    .done      (acc_done),
    .rdata     (acc_rdata),
    .saddress  (saddress),
    .swr       (swr),
    .srd       (srd),
    .sdata_out (sdata_out),
    .sdata_in  (sdata_in)
  );

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// tb/tb_gpioemu_bus_master.sv - directed self-checking bench for gpioemu_bus_master
module tb_gpioemu_bus_master;
  import gpioemu_pkg::*;

  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [23:0] job_a1 = 24'h0;
  logic [23:0] job_a2 = 24'h0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_w;
  logic [5:0]  res_ones;
  logic        res_ovf;
  logic        res_timeout;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in = 32'h0;
  logic        busy;
  logic [15:0] job_count;

  int tests = 0;
  int failed = 0;

  // bus model state, written only by the model process
  int          ctrl_reads = 0, w_reads = 0, l_reads = 0, wr_cnt = 0;
  logic [15:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          seen = 0, len_bad = 0, both_bad = 0, addr_bad = 0, hi = 0;
  logic        p_swr = 1'b0, p_srd = 1'b0;
  logic [15:0] p_addr = 16'h0;
  int          k;

  // model configuration, written only by the test tasks
  logic [1:0]  stat [8];
  int          stat_base = 0;
  logic [31:0] w_val = 32'h0, l_val = 32'h0;

  always #5 clk = ~clk;

  gpioemu_bus_master #(.STROBE_LEN(SL), .POLL_GAP(4), .POLL_LIMIT(3)) dut (
    .clk(clk), .n_reset(n_reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_a1(job_a1), .job_a2(job_a2), .res_valid(res_valid), .res_ready(res_ready),
    .res_w(res_w), .res_ones(res_ones), .res_ovf(res_ovf), .res_timeout(res_timeout),
    .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in),
    .busy(busy), .job_count(job_count)
  );

  // peripheral model plus strobe-shape monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (srd && !p_srd) begin
      if (saddress == ADDR_CTRL) begin
        k = ctrl_reads - stat_base;
        if (k > 7) k = 7;
        sdata_in   <= {30'h0, stat[k]};
        ctrl_reads <= ctrl_reads + 1;
      end else if (saddress == ADDR_W) begin
        sdata_in <= w_val;
        w_reads  <= w_reads + 1;
      end else if (saddress == ADDR_L) begin
        sdata_in <= l_val;
        l_reads  <= l_reads + 1;
      end
    end
    if (swr && !p_swr && wr_cnt < 64) begin
      wr_addr[wr_cnt] <= saddress;
      wr_data[wr_cnt] <= sdata_out;
      wr_cnt          <= wr_cnt + 1;
    end
    if (swr && srd) both_bad <= both_bad + 1;
    if ((swr || srd) && !(p_swr || p_srd)) begin
      seen <= seen + 1;
      hi   <= 1;
      if (saddress !== p_addr) addr_bad <= addr_bad + 1;
    end else if (swr || srd) begin
      hi <= hi + 1;
    end else if (p_swr || p_srd) begin
      if (hi != SL) len_bad <= len_bad + 1;
      if (saddress !== p_addr) addr_bad <= addr_bad + 1;
    end
    p_swr  <= swr;
    p_srd  <= srd;
    p_addr <= saddress;
  end

  task automatic set_model(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] rest,
                           input logic [31:0] w, input logic [31:0] l);
    stat[0] = s0;
    stat[1] = s1;
    for (int i = 2; i < 8; i++) stat[i] = rest;
    stat_base = ctrl_reads;
    w_val = w;
    l_val = l;
  endtask

  task automatic start_job(input logic [23:0] a1, input logic [23:0] a2, output bit ok);
    ok = 1'b0;
    job_a1 = a1;
    job_a2 = a2;
    job_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin ok = 1'b1; break; end
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      lat++;
      if (res_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    job_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (job_ready !== 1'b1) begin failed++; $display("FAIL reset_job_ready got=%b exp=1", job_ready); end
    tests++; if (res_valid !== 1'b0) begin failed++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (job_count !== 16'h0) begin failed++; $display("FAIL reset_job_count got=%0h exp=0", job_count); end
    tests++; if ({swr, srd} !== 2'b00) begin failed++; $display("FAIL reset_strobes got=%b exp=00", {swr, srd}); end
    tests++; if (saddress !== 16'h0 || sdata_out !== 32'h0) begin failed++; $display("FAIL reset_bus got=%0h/%0h exp=0/0", saddress, sdata_out); end
    tests++; if ({res_w, res_ones, res_ovf, res_timeout} !== 40'h0) begin failed++; $display("FAIL reset_res got=%0h exp=0", {res_w, res_ones, res_ovf, res_timeout}); end
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_midjob_reset;
    bit ok;
    bit hit;
    int s0;
    set_model(2'b11, 2'b11, 2'b11, 32'h1, 32'h1);
    start_job(24'h11, 24'h22, ok);
    tests++; if (!ok) begin failed++; $display("FAIL midrst_accept got=0 exp=1"); end
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (swr && saddress == ADDR_A2) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin failed++; $display("FAIL midrst_wr_a2_strobe got=0 exp=1"); end
    n_reset = 1'b0;
    @(posedge clk); #1;
    s0 = seen;
    tests++; if (swr !== 1'b0) begin failed++; $display("FAIL midrst_swr got=%b exp=0", swr); end
    tests++; if (job_ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL midrst_idle got=%b%b exp=10", job_ready, busy); end
    tests++; if (res_valid !== 1'b0) begin failed++; $display("FAIL midrst_res_valid got=%b exp=0", res_valid); end
    tests++; if (job_count !== 16'h0) begin failed++; $display("FAIL midrst_job_count got=%0h exp=0", job_count); end
    n_reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests++; if (seen != s0 || busy !== 1'b0) begin failed++; $display("FAIL midrst_no_access got=%0d busy=%b exp=0 busy=0", seen - s0, busy); end
  endtask

  task automatic test_basic;
    bit ok;
    int lat;
    int wb;
    int cb;
    wb = wr_cnt;
    cb = ctrl_reads;
    set_model(2'b01, 2'b11, 2'b11, 32'h0000_000F, 32'hFFFF_FFC4);
    start_job(24'd3, 24'd5, ok);
    wait_result(lat, ok);
    tests++; if (!ok) begin failed++; $display("FAIL basic_res_valid got=0 exp=1"); end
    tests++; if (wr_cnt - wb != 3) begin failed++; $display("FAIL basic_write_count got=%0d exp=3", wr_cnt - wb); end
    tests++; if (wr_addr[wb] !== ADDR_A1 || wr_data[wb] !== 32'd3) begin failed++; $display("FAIL basic_wr_a1 got=%0h<-%0h exp=380<-3", wr_addr[wb], wr_data[wb]); end
    tests++; if (wr_addr[wb+1] !== ADDR_A2 || wr_data[wb+1] !== 32'd5) begin failed++; $display("FAIL basic_wr_a2 got=%0h<-%0h exp=388<-5", wr_addr[wb+1], wr_data[wb+1]); end
    tests++; if (wr_addr[wb+2] !== ADDR_CTRL || wr_data[wb+2] !== 32'd0) begin failed++; $display("FAIL basic_wr_go got=%0h<-%0h exp=3a0<-0", wr_addr[wb+2], wr_data[wb+2]); end
    tests++; if (ctrl_reads - cb != 2) begin failed++; $display("FAIL basic_polls got=%0d exp=2", ctrl_reads - cb); end
    tests++; if (res_w !== 32'hF) begin failed++; $display("FAIL basic_res_w got=%0h exp=f", res_w); end
    tests++; if (res_ones !== 6'd4) begin failed++; $display("FAIL basic_res_ones got=%0d exp=4", res_ones); end
    tests++; if (res_ovf !== 1'b0 || res_timeout !== 1'b0) begin failed++; $display("FAIL basic_flags got=%b%b exp=00", res_ovf, res_timeout); end
    ack();
    tests++; if (job_count !== 16'd1 || res_valid !== 1'b0) begin failed++; $display("FAIL basic_job_count got=%0d rv=%b exp=1 rv=0", job_count, res_valid); end
  endtask

  task automatic test_strobe_timing;
    bit ok;
    int lat;
    int s0, lb, bb, ab;
    s0 = seen; lb = len_bad; bb = both_bad; ab = addr_bad;
    set_model(2'b11, 2'b11, 2'b11, 32'h1234_5678, 32'd9);
    start_job(24'h000123, 24'h000456, ok);
    wait_result(lat, ok);
    tests++; if (!ok || lat != 6 * (SL + 2) + 1) begin failed++; $display("FAIL strobe_latency got=%0d exp=%0d", lat, 6 * (SL + 2) + 1); end
    tests++; if (seen - s0 != 6) begin failed++; $display("FAIL strobe_count got=%0d exp=6", seen - s0); end
    tests++; if (len_bad != lb) begin failed++; $display("FAIL strobe_length got=%0d bad exp=0", len_bad - lb); end
    tests++; if (both_bad != bb) begin failed++; $display("FAIL strobe_overlap got=%0d exp=0", both_bad - bb); end
    tests++; if (addr_bad != ab) begin failed++; $display("FAIL strobe_addr_stable got=%0d bad exp=0", addr_bad - ab); end
    ack();
  endtask

  task automatic test_overflow;
    bit ok;
    int lat;
    int wb;
    wb = wr_cnt;
    set_model(2'b00, 2'b11, 2'b11, 32'hFE00_0001, 32'd35);
    start_job(24'hFFFFFF, 24'hFFFFFF, ok);
    wait_result(lat, ok);
    tests++; if (!ok) begin failed++; $display("FAIL ovf_res_valid got=0 exp=1"); end
    tests++; if (wr_data[wb] !== 32'h00FF_FFFF || wr_data[wb+1] !== 32'h00FF_FFFF) begin failed++; $display("FAIL ovf_wr_data got=%0h/%0h exp=ffffff", wr_data[wb], wr_data[wb+1]); end
    tests++; if (res_ovf !== 1'b1) begin failed++; $display("FAIL ovf_flag got=%b exp=1", res_ovf); end
    tests++; if (res_w !== 32'hFE00_0001) begin failed++; $display("FAIL ovf_res_w got=%0h exp=fe000001", res_w); end
    tests++; if (res_ones !== 6'd35 || res_timeout !== 1'b0) begin failed++; $display("FAIL ovf_ones_to got=%0d/%b exp=35/0", res_ones, res_timeout); end
    ack();
  endtask

  task automatic test_timeout;
    bit ok;
    int lat;
    int cb, wrb, lrb;
    cb = ctrl_reads; wrb = w_reads; lrb = l_reads;
    set_model(2'b01, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'd7);
    start_job(24'd10, 24'd20, ok);
    wait_result(lat, ok);
    tests++; if (!ok) begin failed++; $display("FAIL to_res_valid got=0 exp=1"); end
    tests++; if (ctrl_reads - cb != 3) begin failed++; $display("FAIL to_polls got=%0d exp=3", ctrl_reads - cb); end
    tests++; if (w_reads != wrb || l_reads != lrb) begin failed++; $display("FAIL to_no_reads got=%0d/%0d exp=0/0", w_reads - wrb, l_reads - lrb); end
    tests++; if (res_timeout !== 1'b1) begin failed++; $display("FAIL to_flag got=%b exp=1", res_timeout); end
    tests++; if (res_w !== 32'h0 || res_ones !== 6'h0 || res_ovf !== 1'b0) begin failed++; $display("FAIL to_res got=%0h/%0d/%b exp=0/0/0", res_w, res_ones, res_ovf); end
    ack();
    tests++; if (job_count !== 16'd4) begin failed++; $display("FAIL to_job_count got=%0d exp=4", job_count); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int lat;
    int wb;
    set_model(2'b11, 2'b11, 2'b11, 32'h0000_003F, 32'd6);
    start_job(24'd7, 24'd9, ok);
    wait_result(lat, ok);
    tests++; if (!ok) begin failed++; $display("FAIL bp_res_valid got=0 exp=1"); end
    wb = wr_cnt;
    set_model(2'b11, 2'b11, 2'b11, 32'h0000_0008, 32'd1);
    job_a1 = 24'd2;
    job_a2 = 24'd4;
    job_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (res_valid !== 1'b1 || res_w !== 32'h3F || res_ones !== 6'd6 || job_ready !== 1'b0 || res_ovf !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold cycle=%0d got=%b/%0h/%0d/%b exp=1/3f/6/0", i, res_valid, res_w, res_ones, job_ready);
      end
    end
    ack();
    tests++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL bp_release got=%b%b%b exp=010", res_valid, job_ready, busy); end
    tests++; if (job_count !== 16'd5) begin failed++; $display("FAIL bp_job_count got=%0d exp=5", job_count); end
    @(posedge clk); #1;
    job_valid = 1'b0;
    tests++; if (busy !== 1'b1 || job_ready !== 1'b0) begin failed++; $display("FAIL bp_next_accept got=%b%b exp=10", busy, job_ready); end
    wait_result(lat, ok);
    tests++; if (!ok || res_w !== 32'h8 || wr_data[wb] !== 32'd2) begin failed++; $display("FAIL bp_second_job got=%0h a1=%0h exp=8 a1=2", res_w, wr_data[wb]); end
    ack();
    tests++; if (job_count !== 16'd6) begin failed++; $display("FAIL bp_job_count2 got=%0d exp=6", job_count); end
  endtask

  initial begin
    test_reset();
    test_midjob_reset();
    test_basic();
    test_strobe_timing();
    test_overflow();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
